gated_counter_ctrl: RTL and testbench
=====================================

// Module: gated_counter_ctrl
// PURPOSE
//  Gate-window controller for a bank of NCH 32-bit event counters.
//  - Opens a counting window of programmable length, then snapshots all counters.
//  - Presents each snapshot to readout through a valid/ready handshake.
//  - Sits between slow-control registers (start/stop/length) and the readout path.
//  - Drives per-channel rate measurements on the ROC.
// PARAMETERS
//  NCH    4   number of event channels / counters
//  WIDTH  32  counter and window-length width
//  IDW    16  window-id width
// PORTS
//  clk         in   1          system clock, all logic on rising edge
//  rst         in   1          synchronous reset, active-high
//  start       in   1          pulse: begin measurement (ignored unless IDLE)
//  stop        in   1          pulse: finish current window, then go IDLE
//  continuous  in   1          1 = re-arm automatically after each window
//  window_len  in   WIDTH      window length in clk cycles; 0 treated as 1
//  event_in    in   NCH        per-channel event strobes, one count per high cycle
//  busy        out  1          high in any state other than IDLE
//  res_valid   out  1          snapshot available
//  res_ready   in   1          readout accepts snapshot
//  res_cnt     out  NCH*WIDTH  snapshot; channel i at [i*WIDTH +: WIDTH]
//  res_sat     out  NCH        per-channel saturation flag of the snapshot
//  res_id      out  IDW        window id of the snapshot
//  overrun     out  1          sticky: a snapshot was dropped; cleared by start or rst
// BEHAVIOUR
//  Reset (rst=1 at an edge)
//  - state=IDLE.
//  - busy, res_valid, res_cnt, res_sat, res_id and overrun all 0.
//  - Internal counters, timer and window id all 0.
//  - Reset mid-window discards the window; no snapshot is produced.
//  FSM: IDLE -> CLEAR -> COUNT -> LATCH -> (CLEAR | IDLE)
//  - IDLE: start=1 -> CLEAR; overrun cleared.
//  - CLEAR (1 cycle)
//    - Counters and sat flags cleared.
//    - timer <= max(window_len,1)-1; window_len is sampled only here.
//    - Next state COUNT.
//  - COUNT
//    - Each counter increments on cycles where its event_in bit = 1.
//    - timer decrements each cycle.
//    - When timer==0 the state moves to LATCH; the window is exactly max(window_len,1) COUNT cycles.
//  - LATCH (1 cycle)
//    - Slot free (res_valid==0, or res_valid&res_ready this cycle): res_cnt/res_sat/res_id <= counters/sat/window id, res_valid<=1.
//    - Slot not free: snapshot discarded, overrun<=1.
//    - Window id increments in either case, wrapping at 2^IDW-1 -> 0.
//    - Next state CLEAR if (continuous && !stop_pend), else IDLE.
//  - Dead time between back-to-back windows: 2 cycles (LATCH, CLEAR); events in those cycles are not counted.
//  stop handling
//  - stop in CLEAR/COUNT sets stop_pend; the window completes normally.
//  - stop_pend is cleared on entering IDLE.
//  - stop in IDLE has no effect.
//  - start while not IDLE is ignored.
//  Counters
//  - Saturate at 2^WIDTH-1 (no wrap).
//  - sat[i] set on an event arriving while the counter is already at max.
//  Handshake
//  - res_valid stays high until res_valid&res_ready.
//  - res_cnt/res_sat/res_id stay stable while res_valid=1.
//  - res_ready is ignored when res_valid=0.
//  - A snapshot accepted and a new snapshot loaded in the same cycle: the new one wins, res_valid stays 1.
//  Latency
//  - start -> first counted cycle: 2 clk.
//  - Last COUNT cycle -> res_valid: 1 clk.
// STRUCTURE
//  - Shared package rocfw_ctrl_pkg: FSM state enum (IDLE, CLEAR, COUNT, LATCH) and default WIDTH/IDW constants.
//  - One sub-module, sat_event_counter: WIDTH-bit up counter with sync clear, enable and sat flag.
//    - Instantiated NCH times via generate.
//  - FSM, timer, window id and result register in this module.
// TESTING
//  1. start, window_len=10, continuous=0, event_in[0]=1 constant
//     -> res_cnt[0]=10, other channels 0, res_id=0, busy falls 1 cycle after res_valid rises.
//  2. window_len=0, event_in=4'b1111
//     -> every channel counts 1; FSM returns to IDLE.
//  3. continuous=1, window_len=5, res_ready=1, event_in[1] toggling every cycle from reset
//     -> successive snapshots with res_id 0,1,2; dead time of 2 cycles per window.
//  4. continuous=1, res_ready=0 for 3 windows
//     -> first snapshot (id 0) held stable, overrun=1; after res_ready, res_id=0 is read, then the next completed window.
//  5. Preload via long window with WIDTH=8 override, event_in[2]=1 for 300 cycles
//     -> res_cnt[2]=255, res_sat[2]=1.
//  6. rst mid-COUNT, then stop during a continuous run
//     -> rst gives all outputs 0 and no snapshot; stop finishes the current window, one snapshot, then IDLE.

Source files
------------

// File: rtl/rocfw_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rocfw_ctrl_pkg
// Shared definitions for the readout-controller gate-window logic.
//   state_t     : gate-window FSM states (IDLE, CLEAR, COUNT, LATCH)
//   DEF_NCH     : default number of event channels
//   DEF_WIDTH   : default counter / window-length width
//   DEF_IDW     : default window-id width
// ----------------------------------------------------------------------------
package rocfw_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_COUNT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    localparam int DEF_NCH   = 32'd4;
    localparam int DEF_WIDTH = 32'd32;
    localparam int DEF_IDW   = 32'd16;

endpackage

// File: rtl/sat_event_counter.sv
// ----------------------------------------------------------------------------
// sat_event_counter
// WIDTH-bit saturating event counter with synchronous clear and count enable.
// The outputs are the look-ahead (next-state) values, so the owner can take a
// snapshot on the same edge that registers the final counting cycle.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   clr       in   synchronous clear of count and saturation flag
//   en        in   counting window active
//   ev        in   event strobe, one count per high cycle while en=1
//   cnt_next  out  value the counter takes at the next edge
//   sat_next  out  value the saturation flag takes at the next edge
// ----------------------------------------------------------------------------
module sat_event_counter
    import rocfw_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ev,
    output logic [WIDTH-1:0] cnt_next,
    output logic             sat_next
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;
    logic             sat_r;
    logic [WIDTH-1:0] cnt_d_s;
    logic             sat_d_s;

    // Next-state: clear wins, otherwise count events and pin at the maximum
    always_comb begin
        cnt_d_s = cnt_r;
        sat_d_s = sat_r;
        if (clr) begin
            cnt_d_s = {WIDTH{1'b0}};
            sat_d_s = 1'b0;
        end else if (en && ev) begin
            if (cnt_r == CNT_MAX) begin
                sat_d_s = 1'b1;
            end else begin
                cnt_d_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_d_s = cnt_r;
            sat_d_s = sat_r;
        end
    end

    // Counter and saturation flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {WIDTH{1'b0}};
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_d_s;
            sat_r <= sat_d_s;
        end
    end

    assign cnt_next = cnt_d_s;
    assign sat_next = sat_d_s;

endmodule

// File: rtl/gated_counter_ctrl.sv
// ----------------------------------------------------------------------------
// gated_counter_ctrl
// Gate-window controller for a bank of NCH saturating event counters. A start
// pulse opens a window of window_len cycles (0 behaves as 1); at its end all
// counters are snapshotted into a result register offered over valid/ready.
// In continuous mode windows re-arm with two dead cycles (LATCH, CLEAR).
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        begin measurement (IDLE only); clears overrun
//   stop         finish the current window, then return to IDLE
//   continuous   re-arm after each window
//   window_len   window length in cycles, sampled in CLEAR
//   event_in     per-channel event strobes
//   busy         FSM not in IDLE
//   res_valid    snapshot available; held until accepted
//   res_ready    readout accepts snapshot
//   res_cnt      snapshot counts, channel i at [i*WIDTH +: WIDTH]
//   res_sat      snapshot saturation flags
//   res_id       window id of the snapshot
//   overrun      sticky: a snapshot was dropped because the slot was full
// ----------------------------------------------------------------------------
module gated_counter_ctrl
    import rocfw_ctrl_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = DEF_IDW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 continuous,
    input  logic [WIDTH-1:0]     window_len,
    input  logic [NCH-1:0]       event_in,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NCH*WIDTH-1:0] res_cnt,
    output logic [NCH-1:0]       res_sat,
    output logic [IDW-1:0]       res_id,
    output logic                 overrun
);

    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]   ID_ONE = {{(IDW-1){1'b0}}, 1'b1};

    // Timer start value: a zero-length window still counts for one cycle
    function automatic logic [WIDTH-1:0] first_timer(input logic [WIDTH-1:0] len);
        if (len == W_ZERO) begin
            return W_ZERO;
        end else begin
            return len - W_ONE;
        end
    endfunction

    state_t               state_r;
    logic                 busy_r;
    logic [WIDTH-1:0]     timer_r;
    logic [IDW-1:0]       win_id_r;
    logic                 stop_pend_r;
    logic                 res_valid_r;
    logic [NCH*WIDTH-1:0] res_cnt_r;
    logic [NCH-1:0]       res_sat_r;
    logic [IDW-1:0]       res_id_r;
    logic                 overrun_r;

    logic                 cnt_clr_s;
    logic                 cnt_en_s;
    logic                 last_cnt_s;
    logic                 slot_free_s;
    logic                 res_load_s;
    logic                 res_drop_s;
    logic [NCH*WIDTH-1:0] cnt_next_s;
    logic [NCH-1:0]       sat_next_s;

    // Counter bank; snapshots use the look-ahead values so the final
    // COUNT cycle's events are included and res_valid rises in LATCH
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        sat_event_counter #(
            .WIDTH (WIDTH)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr      (cnt_clr_s),
            .en       (cnt_en_s),
            .ev       (event_in[gi]),
            .cnt_next (cnt_next_s[gi*WIDTH +: WIDTH]),
            .sat_next (sat_next_s[gi])
        );
    end

    // Window control decode and result-slot arbitration
    always_comb begin
        cnt_clr_s   = (state_r == ST_CLEAR);
        cnt_en_s    = (state_r == ST_COUNT);
        last_cnt_s  = cnt_en_s && (timer_r == W_ZERO);
        // slot is free when empty or being drained on this very edge
        slot_free_s = !res_valid_r || res_ready;
        res_load_s  = last_cnt_s && slot_free_s;
        res_drop_s  = last_cnt_s && !slot_free_s;
    end

    // Gate-window FSM with timer, window id, pending stop and busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            timer_r     <= W_ZERO;
            win_id_r    <= {IDW{1'b0}};
            stop_pend_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    timer_r     <= first_timer(window_len);
                    stop_pend_r <= stop_pend_r | stop;
                    state_r     <= ST_COUNT;
                end
                ST_COUNT: begin
                    stop_pend_r <= stop_pend_r | stop;
                    if (timer_r == W_ZERO) begin
                        // id advances whether the snapshot is kept or dropped
                        state_r  <= ST_LATCH;
                        win_id_r <= win_id_r + ID_ONE;
                    end else begin
                        timer_r <= timer_r - W_ONE;
                    end
                end
                ST_LATCH: begin
                    if (continuous && !stop_pend_r) begin
                        state_r <= ST_CLEAR;
                    end else begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        stop_pend_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    stop_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Result slot: a new snapshot overrides a simultaneous acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_r <= 1'b0;
            res_cnt_r   <= {(NCH*WIDTH){1'b0}};
            res_sat_r   <= {NCH{1'b0}};
            res_id_r    <= {IDW{1'b0}};
            overrun_r   <= 1'b0;
        end else begin
            if (res_load_s) begin
                res_valid_r <= 1'b1;
                res_cnt_r   <= cnt_next_s;
                res_sat_r   <= sat_next_s;
                res_id_r    <= win_id_r;
            end else if (res_valid_r && res_ready) begin
                res_valid_r <= 1'b0;
            end else begin
                res_valid_r <= res_valid_r;
            end

            if ((state_r == ST_IDLE) && start) begin
                overrun_r <= 1'b0;
            end else if (res_drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign res_cnt   = res_cnt_r;
    assign res_sat   = res_sat_r;
    assign res_id    = res_id_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_gated_counter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gated_counter_ctrl
// Self-checking bench for gated_counter_ctrl. A behavioural model tracks the
// window by its position since CLEAR and accumulates events with plain
// arithmetic; every cycle the DUT outputs are compared with it, and each
// scenario adds explicit checks on the values it is about.
// ----------------------------------------------------------------------------
module tb_gated_counter_ctrl;

    localparam int     NCH     = 4;
    localparam int     WIDTH   = 32;
    localparam int     IDW     = 16;
    localparam int     VW      = 3 + IDW + NCH + NCH * WIDTH;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic                 clk        = 1'b0;
    logic                 rst        = 1'b1;
    logic                 start      = 1'b0;
    logic                 stop       = 1'b0;
    logic                 continuous = 1'b0;
    logic [WIDTH-1:0]     window_len = 32'd0;
    logic [NCH-1:0]       event_in   = 4'd0;
    logic                 res_ready  = 1'b0;
    logic                 busy;
    logic                 res_valid;
    logic [NCH*WIDTH-1:0] res_cnt;
    logic [NCH-1:0]       res_sat;
    logic [IDW-1:0]       res_id;
    logic                 overrun;

    // stand-alone 8-bit counter to reach saturation in a short run
    logic       s_clr = 1'b0;
    logic       s_en  = 1'b0;
    logic       s_ev  = 1'b0;
    logic [7:0] s_cnt;
    logic       s_sat;

    int n_checks = 0;
    int n_fail   = 0;

    gated_counter_ctrl #(.NCH(NCH), .WIDTH(WIDTH), .IDW(IDW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .window_len (window_len),
        .event_in   (event_in),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_cnt    (res_cnt),
        .res_sat    (res_sat),
        .res_id     (res_id),
        .overrun    (overrun)
    );

    sat_event_counter #(.WIDTH(8)) u_sat (
        .clk      (clk),
        .rst      (rst),
        .clr      (s_clr),
        .en       (s_en),
        .ev       (s_ev),
        .cnt_next (s_cnt),
        .sat_next (s_sat)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit             m_run, m_stop, m_ovr, m_valid;
    int             m_pos;       // 0 = clear cycle, 1..m_len = counting, m_len+1 = latch
    longint         m_len;
    longint         m_acc  [NCH];
    bit [NCH-1:0]   m_asat;
    longint         m_slot [NCH];
    bit [NCH-1:0]   m_rsat;
    int             m_id, m_rid;

    task automatic model_step();
        bit accept;
        bit loaded;
        accept = m_valid && res_ready;
        loaded = 1'b0;
        if (rst) begin
            m_run = 0; m_stop = 0; m_ovr = 0; m_valid = 0; m_pos = 0;
            m_id = 0; m_rid = 0; m_asat = '0; m_rsat = '0;
            for (int i = 0; i < NCH; i++) begin m_acc[i] = 0; m_slot[i] = 0; end
            return;
        end
        if (!m_run) begin
            if (start) begin m_run = 1; m_pos = 0; m_ovr = 0; end
        end else if (m_pos == 0) begin
            m_len = (window_len == 0) ? 1 : longint'(window_len);
            for (int i = 0; i < NCH; i++) m_acc[i] = 0;
            m_asat = '0;
            if (stop) m_stop = 1;
            m_pos = 1;
        end else if (m_pos <= m_len) begin
            if (stop) m_stop = 1;
            for (int i = 0; i < NCH; i++) begin
                if (event_in[i]) begin
                    if (m_acc[i] == CNT_MAX) m_asat[i] = 1'b1;
                    else m_acc[i] = m_acc[i] + 1;
                end
            end
            if (m_pos == m_len) begin
                if (!m_valid || accept) begin
                    for (int i = 0; i < NCH; i++) m_slot[i] = m_acc[i];
                    m_rsat = m_asat; m_rid = m_id; loaded = 1'b1;
                end else begin
                    m_ovr = 1;
                end
                m_id = (m_id + 1) % (1 << IDW);
            end
            m_pos++;
        end else begin
            if (continuous && !m_stop) m_pos = 0;
            else begin m_run = 0; m_stop = 0; end
        end
        if (loaded) m_valid = 1;
        else if (accept) m_valid = 0;
    endtask

    function automatic logic [VW-1:0] mdl_vec();
        logic [NCH*WIDTH-1:0] flat;
        for (int i = 0; i < NCH; i++) flat[i*WIDTH +: WIDTH] = m_slot[i][WIDTH-1:0];
        return {m_run, m_valid, m_ovr, m_rid[IDW-1:0], m_rsat, flat};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {busy, res_valid, overrun, res_id, res_sat, res_cnt};
    endfunction

    // advance one clock: model consumes the inputs seen at the edge
    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [VW-1:0] zero_v;
        zero_v = '0;
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (dut_vec() !== zero_v) begin
            n_fail++; $display("FAIL reset_state: dut=%h want=%h", dut_vec(), zero_v);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL reset_idle: dut=%h model=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_single_window();
        int rise_c = -1;
        int fall_c = -1;
        window_len = 32'd10; continuous = 1'b0; event_in = 4'b0001; res_ready = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick(); start = 1'b0;
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL single_window cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
            if (res_valid && rise_c < 0) rise_c = c;
            if (!busy && fall_c < 0) fall_c = c;
        end
        n_checks++;
        if (res_cnt[31:0] !== 32'd10 || res_cnt[127:32] !== 96'd0 || res_id !== 16'd0) begin
            n_fail++; $display("FAIL single_window_cnt: cnt=%h id=%0d want ch0=10 others 0 id 0", res_cnt, res_id);
        end
        n_checks++;
        if (rise_c != 11 || fall_c != 12) begin
            n_fail++; $display("FAIL single_window_timing: valid at %0d busy low at %0d want 11 and 12", rise_c, fall_c);
        end
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_window_accept: res_valid=%b want 0", res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_zero_len();
        window_len = 32'd0; event_in = 4'b1111; res_ready = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick(); start = 1'b0;
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL zero_len cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
        end
        n_checks++;
        if (res_cnt !== {32'd1, 32'd1, 32'd1, 32'd1} || busy !== 1'b0 || res_valid !== 1'b1 || res_id !== 16'd1) begin
            n_fail++; $display("FAIL zero_len_result: cnt=%h busy=%b valid=%b id=%0d want all 1, 0, 1, 1", res_cnt, busy, res_valid, res_id);
        end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
    endtask

    task automatic test_continuous();
        int ids[$];
        int cyc[$];
        rst = 1'b1; tick(); rst = 1'b0;
        continuous = 1'b1; window_len = 32'd5; res_ready = 1'b1; event_in = 4'b0000;
        start = 1'b1;
        for (int c = 0; c < 24; c++) begin
            event_in[1] = ~event_in[1];
            tick(); start = 1'b0;
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL continuous cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
            if (res_valid) begin ids.push_back(int'(res_id)); cyc.push_back(c); end
        end
        n_checks++;
        if (ids.size() != 3) begin
            n_fail++; $display("FAIL continuous_count: snapshots=%0d want 3", ids.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (ids[k] != k || cyc[k] != 6 + 7 * k) begin
                    n_fail++; $display("FAIL continuous_id%0d: id=%0d cyc=%0d want id %0d cyc %0d", k, ids[k], cyc[k], k, 6 + 7 * k);
                end
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL continuous_stop cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL continuous_idle: busy=%b want 0", busy);
        end
        continuous = 1'b0;
    endtask

    task automatic test_overrun();
        bit got;
        rst = 1'b1; tick(); rst = 1'b0;
        continuous = 1'b1; window_len = 32'd4; res_ready = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 21; c++) begin
            event_in = 4'($urandom_range(0, 15));
            tick(); start = 1'b0;
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL overrun cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 16'd0 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_hold: valid=%b id=%0d overrun=%b want 1 0 1", res_valid, res_id, overrun);
        end
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL overrun_accept: res_valid=%b want 0", res_valid);
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL overrun_drain cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
            if (res_valid) got = 1'b1;
        end
        n_checks++;
        if (!got || res_id !== 16'd3) begin
            n_fail++; $display("FAIL overrun_next: seen=%b id=%0d want 1 and id 3", got, res_id);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        continuous = 1'b0; res_ready = 1'b0;
    endtask

    task automatic test_stop_reset();
        logic [VW-1:0] zero_v;
        int nval;
        zero_v = '0;
        rst = 1'b1; tick(); rst = 1'b0;
        continuous = 1'b0; window_len = 32'd20; event_in = 4'b1010; res_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if (dut_vec() !== zero_v) begin
            n_fail++; $display("FAIL reset_midcount: dut=%h want=%h", dut_vec(), zero_v);
        end
        nval = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL reset_after cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
            if (res_valid) nval++;
        end
        n_checks++;
        if (nval != 0) begin
            n_fail++; $display("FAIL reset_no_snapshot: snapshots=%0d want 0", nval);
        end
        continuous = 1'b1; window_len = 32'd3;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            event_in = 4'($urandom_range(0, 15));
            tick();
        end
        stop = 1'b1;
        nval = 0;
        for (int c = 0; c < 10; c++) begin
            tick(); stop = 1'b0;
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL stop cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
            if (res_valid) begin
                nval++;
                n_checks++;
                if (res_id !== 16'd2) begin
                    n_fail++; $display("FAIL stop_id: id=%0d want 2", res_id);
                end
            end
        end
        n_checks++;
        if (nval != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_final: snapshots=%0d busy=%b want 1 and 0", nval, busy);
        end
        continuous = 1'b0;
    endtask

    task automatic test_saturation();
        s_clr = 1'b1; tick(); s_clr = 1'b0;
        s_en = 1'b1; s_ev = 1'b1;
        for (int c = 0; c < 255; c++) tick();
        s_en = 1'b0; tick();
        n_checks++;
        if ({s_sat, s_cnt} !== {1'b0, 8'hFF}) begin
            n_fail++; $display("FAIL sat_at_max: sat=%b cnt=%0d want 0 255", s_sat, s_cnt);
        end
        s_en = 1'b1;
        for (int c = 0; c < 45; c++) tick();
        s_en = 1'b0; tick();
        n_checks++;
        if ({s_sat, s_cnt} !== {1'b1, 8'hFF}) begin
            n_fail++; $display("FAIL sat_over: sat=%b cnt=%0d want 1 255", s_sat, s_cnt);
        end
        s_clr = 1'b1; tick(); s_clr = 1'b0; s_ev = 1'b0; tick();
        n_checks++;
        if ({s_sat, s_cnt} !== 9'd0) begin
            n_fail++; $display("FAIL sat_clear: sat=%b cnt=%0d want 0 0", s_sat, s_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) continuous = ~continuous;
            window_len = 32'($urandom_range(0, 9));
            event_in   = 4'($urandom_range(0, 15));
            res_ready  = $urandom_range(0, 1) == 1;
            tick();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: dut=%h model=%h", c, dut_vec(), mdl_vec());
            end
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_zero_len();
        test_continuous();
        test_overrun();
        test_stop_reset();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
